// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through, or issues one aligned load/store on a
// simple req/ack bus and produces a single registered writeback pulse per instruction.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_store_data,
  input  logic [63:0] i_result,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic [31:0] wb_pc,
  output logic        o_misaligned,
  output logic        fsm_state
);

  // Bus handshake: mem_req rises with address/data/strobes valid and holds them
  // unchanged until the cycle mem_ack=1 is sampled; mem_ack is ignored outside BUSY.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state;
  logic        lat_load;
  logic        lat_unsigned;
  logic        lat_flushed;
  logic [1:0]  lat_size;
  logic [2:0]  lat_off;
  logic [4:0]  lat_rd;
  logic [31:0] lat_pc;

  logic        is_mem;
  logic        misaligned;
  logic [7:0]  base_strb;
  logic [7:0]  store_strb;
  logic [63:0] store_wdata;
  logic [63:0] load_shifted;
  logic [63:0] load_val;

  assign fsm_state = state;
  assign is_mem    = i_is_load | i_is_store;

  always_comb begin
    misaligned = 1'b0;
    base_strb  = 8'h01;
    case (i_size)
      2'd0: begin misaligned = 1'b0;           base_strb = 8'h01; end
      2'd1: begin misaligned = i_addr[0];      base_strb = 8'h03; end
      2'd2: begin misaligned = |i_addr[1:0];   base_strb = 8'h0F; end
      default: begin misaligned = |i_addr[2:0]; base_strb = 8'hFF; end
    endcase
  end

  assign store_strb   = base_strb << i_addr[2:0];
  assign store_wdata  = i_store_data << {i_addr[2:0], 3'b000};
  assign load_shifted = mem_rdata >> {lat_off, 3'b000};

  always_comb begin
    load_val = load_shifted;
    case (lat_size)
      2'd0: load_val = lat_unsigned ? {56'd0, load_shifted[7:0]}
                                    : {{56{load_shifted[7]}}, load_shifted[7:0]};
      2'd1: load_val = lat_unsigned ? {48'd0, load_shifted[15:0]}
                                    : {{48{load_shifted[15]}}, load_shifted[15:0]};
      2'd2: load_val = lat_unsigned ? {32'd0, load_shifted[31:0]}
                                    : {{32{load_shifted[31]}}, load_shifted[31:0]};
      default: load_val = load_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      o_stall      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 64'd0;
      mem_wdata    <= 64'd0;
      mem_wstrb    <= 8'd0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 64'd0;
      wb_pc        <= 32'd0;
      o_misaligned <= 1'b0;
      lat_load     <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_flushed  <= 1'b0;
      lat_size     <= 2'd0;
      lat_off      <= 3'd0;
      lat_rd       <= 5'd0;
      lat_pc       <= 32'd0;
    end else begin
      wb_valid     <= 1'b0;
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && !i_flush) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_rd    <= i_rd;
              wb_data  <= i_result;
              wb_pc    <= i_pc;
            end else if (misaligned) begin
              o_misaligned <= 1'b1;
              wb_valid     <= 1'b1;
              wb_rd        <= 5'd0;
              wb_data      <= 64'd0;
              wb_pc        <= i_pc;
            end else begin
              state        <= BUSY;
              o_stall      <= 1'b1;
              mem_req      <= 1'b1;
              mem_we       <= i_is_store;
              mem_addr     <= {i_addr[63:3], 3'b000};
              mem_wdata    <= i_is_store ? store_wdata : 64'd0;
              mem_wstrb    <= i_is_store ? store_strb : 8'd0;
              lat_load     <= i_is_load;
              lat_unsigned <= i_unsigned;
              lat_flushed  <= 1'b0;
              lat_size     <= i_size;
              lat_off      <= i_addr[2:0];
              lat_rd       <= i_rd;
              lat_pc       <= i_pc;
            end
          end
        end
        BUSY: begin
          if (i_flush) lat_flushed <= 1'b1;
          if (mem_ack) begin
            state     <= IDLE;
            o_stall   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 64'd0;
            mem_wdata <= 64'd0;
            mem_wstrb <= 8'd0;
            // A flush seen at any point while busy, even on the ack cycle, kills writeback.
            if (!(lat_flushed || i_flush)) begin
              wb_valid <= 1'b1;
              wb_pc    <= lat_pc;
              wb_rd    <= lat_load ? lat_rd : 5'd0;
              wb_data  <= lat_load ? load_val : 64'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
